// File: rtl/vmicro16_mem_arb_pkg.sv
// vmicro16_mem_arb_pkg: shared state encodings and helpers for the BRAM arbiter.
package vmicro16_mem_arb_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1) % n;
   endfunction
endpackage

// File: rtl/vmicro16_rr_pick.sv
// vmicro16_rr_pick: combinational round-robin pick, first requester at or after ptr.
module vmicro16_rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] index
);
   logic [PW-1:0] j;
   // Walk from the farthest candidate back to ptr so the nearest one wins.
   always_comb begin
      valid = |req;
      index = '0;
      j = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = PW'((int'(ptr) + k) % N);
         if (req[j]) index = j;
      end
   end
endmodule

// File: rtl/vmicro16_mem_arb.sv
// vmicro16_mem_arb: round-robin arbiter giving NUM_PORTS requesters access to one
// single-port BRAM, one access per IDLE -> ISSUE -> RESP transaction.
module vmicro16_mem_arb
   import vmicro16_mem_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS-1:0]            req_valid,
   input  logic [NUM_PORTS-1:0]            req_we,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]            ack,
   output logic [DATA_WIDTH-1:0]           rdata,
   output logic                            busy,
   output logic [DATA_WIDTH-1:0]           mem_addr,
   output logic [DATA_WIDTH-1:0]           mem_in,
   output logic                            mem_we,
   input  logic [DATA_WIDTH-1:0]           mem_out
);
   localparam int PW = $clog2(NUM_PORTS);

   arb_state_t            state_q, state_d;
   logic [PW-1:0]         ptr_q, ptr_d, idx_q, idx_d, pick_idx;
   logic                  we_q, we_d, pick_valid;
   logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

   vmicro16_rr_pick #(.N(NUM_PORTS), .PW(PW)) u_pick (
      .req   (req_valid),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .index (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (pick_valid) begin
            state_d = ISSUE;
            idx_d   = pick_idx;
            ptr_d   = PW'(rr_next(int'(pick_idx), NUM_PORTS));
            we_d    = req_we[pick_idx];
            addr_d  = req_addr[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            wdata_d = req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
         end
         ISSUE: state_d = RESP;
         RESP: begin
            state_d = IDLE;
            rdata_d = we_q ? rdata_q : mem_out;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Read data is forwarded straight from the BRAM during RESP so it lines up with ack.
   always_comb begin
      busy     = state_q != IDLE;
      mem_we   = (state_q == ISSUE) && we_q;
      mem_addr = addr_q;
      mem_in   = wdata_q;
      ack      = (state_q == RESP) ? (NUM_PORTS'(1) << idx_q) : '0;
      rdata    = ((state_q == RESP) && !we_q) ? mem_out : rdata_q;
   end
endmodule
